riscv_scoreboard: RTL
=====================

// Module: riscv_scoreboard
// PURPOSE
//  Issue-side hazard tracker for the dual-issue in-order pipe; sits between decode and
//  the 4r2w regfile/execute. Counts in-flight writes per GPR and decides each cycle
//  whether slot0, and then slot1, may issue. Clears entries on the two writeback ports,
//  which drive the regfile write ports 0/1.
// PARAMETERS
//  CNT_W   2   width of per-GPR pending-write counter; max in-flight writes/reg = 2^CNT_W-1
//  PERF    1   1: implement stall_cycles counter; 0: stall_cycles tied to 0
// PORTS
//  clk            in   1   clock
//  srst_n         in   1   reset, asynchronous assert, active-low
//  id_valid0/1    in   1   decode slot0/1 holds a valid instruction
//  id_rs1_0/1     in   5   slot0/1 rs1 (same indices driven to regfile raddr0/raddr2)
//  id_rs2_0/1     in   5   slot0/1 rs2 (regfile raddr1/raddr3)
//  id_rd_0/1      in   5   slot0/1 destination
//  id_wen_0/1     in   1   slot0/1 writes rd
//  ex_ready       in   1   execute accepts an issue group this cycle
//  flush          in   1   kill all in-flight instructions (redirect)
//  wb_wen0/1      in   1   writeback port0/1 retires a write
//  wb_waddr0/1    in   5   writeback port0/1 register index
//  issue0         out  1   slot0 issues this cycle (combinational)
//  issue1         out  1   slot1 issues this cycle (combinational)
//  busy_vec       out  32  registered; bit i = pending count of x_i != 0; bit0 always 0
//  stall_cycles   out  32  registered; cycles with id_valid0 & ex_ready & ~issue0
// BEHAVIOUR
//  State: cnt[1..31] (CNT_W bits each); x0 never tracked, reads/writes of x0 never hazard.
//  Reset (srst_n=0, async): all cnt=0, busy_vec=0, stall_cycles=0; issue0/issue1 forced 0.
//  Hazard on r: r!=0 && cnt[r]!=0. Scoreboard state is registered only: no same-cycle
//   writeback bypass (regfile has no write-through), so a reg retiring this cycle still
//   blocks readers until the next cycle.
//  issue0 = id_valid0 & ex_ready & ~flush & ~haz(rs1_0) & ~haz(rs2_0)
//           & ~(id_wen_0 & rd_0!=0 & cnt[rd_0]==MAX).
//  issue1 = issue0 & id_valid1 & ~haz(rs1_1) & ~haz(rs2_1)
//           & ~(id_wen_1 & rd_1!=0 & cnt[rd_1]==MAX)
//           & ~(id_wen_0 & rd_0!=0 & (rs1_1==rd_0 | rs2_1==rd_0))  // RAW in pair
//           & ~(id_wen_0 & id_wen_1 & rd_0!=0 & rd_1==rd_0).       // WAW in pair
//  Strict in-order: slot1 never issues without slot0. Operand usage is not decoded here;
//   decode drives unused rs fields to 0.
//  Update at posedge, per r!=0: inc = (issue0&wen_0&rd_0==r) + (issue1&wen_1&rd_1==r);
//   dec = (wb_wen0&wb_waddr0==r) + (wb_wen1&wb_waddr1==r); cnt <= cnt + inc - dec.
//   Same-cycle inc/dec on one reg net out (e.g. cnt=1, inc 1, dec 1 -> 1). Both wb ports
//   on one reg decrement by 2.
//  Underflow (dec > cnt+inc): cnt clamps to 0; sim-only $error. Overflow cannot occur
//   (issue gated at MAX).
//  flush: all cnt <= 0 next edge, overriding inc/dec; issue0/1 = 0 that cycle. Writebacks
//   of killed instructions are suppressed upstream; writebacks of older, non-killed
//   instructions are retired by the pipe before flush is asserted.
//  busy_vec[r] <= (next cnt[r] != 0): matches cnt from the same edge.
//  stall_cycles: +1 per qualifying cycle, wraps at 2^32-1 -> 0; not cleared by flush.
// TESTING
//  T1 reset: srst_n low mid-run with cnt[5]=2 -> busy_vec=0, issue0=0 immediately,
//     stall_cycles=0.
//  T2 pair RAW: slot0 addi x5,x0,1; slot1 add x6,x5,x5; ex_ready=1 -> issue0=1, issue1=0;
//     busy_vec[5]=1 next cycle; slot1 re-presented as slot0 stalls until wb x5, then
//     issues 1 cycle after the wb edge.
//  T3 WAW/saturation (CNT_W=2): 3 single issues writing x7, no wb -> cnt[7]=3; 4th writer
//     of x7 -> issue0=0, stall_cycles +1/cycle; wb x7 once -> issue0=1 next cycle.
//  T4 simultaneous: cnt[9]=1, slot0 writes x9, wb_wen0 x9 same cycle -> cnt[9]=1;
//     wb_wen0 & wb_wen1 both x9 with cnt[9]=2 -> busy_vec[9]=0 next cycle.
//  T5 x0: slot0 rd=x0 wen=1, slot1 rs1=x0 -> both issue; busy_vec[0] stays 0;
//     wb_waddr0=0 ignored.
//  T6 flush: cnt[3]=2, cnt[12]=1, flush=1 with valid hazard-free pair -> issue0/1=0,
//     busy_vec=0 next cycle; ex_ready=0 -> no issue, stall_cycles unchanged.

Source files
------------

// File: rtl/riscv_scoreboard.sv
// Issue-side hazard scoreboard for the dual-issue in-order pipe: per-GPR pending-write
// counters, slot0/slot1 issue decision, and two writeback retire ports.
module riscv_scoreboard #(
   parameter int CNT_W = 2,
   parameter int PERF  = 1
) (
   input  logic        clk,
   input  logic        srst_n,
   input  logic        id_valid0,
   input  logic        id_valid1,
   input  logic [4:0]  id_rs1_0,
   input  logic [4:0]  id_rs1_1,
   input  logic [4:0]  id_rs2_0,
   input  logic [4:0]  id_rs2_1,
   input  logic [4:0]  id_rd_0,
   input  logic [4:0]  id_rd_1,
   input  logic        id_wen_0,
   input  logic        id_wen_1,
   input  logic        ex_ready,
   input  logic        flush,
   input  logic        wb_wen0,
   input  logic        wb_wen1,
   input  logic [4:0]  wb_waddr0,
   input  logic [4:0]  wb_waddr1,
   output logic        issue0,
   output logic        issue1,
   output logic [31:0] busy_vec,
   output logic [31:0] stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt     [32];
   logic [CNT_W-1:0] cnt_nxt [32];
   logic [31:0]      underflow;

   logic haz_rs1_0, haz_rs2_0, haz_rs1_1, haz_rs2_1;
   logic full_rd_0, full_rd_1, raw_pair, waw_pair;
   logic issue0_c, issue1_c;

   // Hazards look only at registered counts: a register retiring this cycle still blocks.
   always_comb begin
      haz_rs1_0 = (id_rs1_0 != '0) && (cnt[id_rs1_0] != '0);
      haz_rs2_0 = (id_rs2_0 != '0) && (cnt[id_rs2_0] != '0);
      haz_rs1_1 = (id_rs1_1 != '0) && (cnt[id_rs1_1] != '0);
      haz_rs2_1 = (id_rs2_1 != '0) && (cnt[id_rs2_1] != '0);
      full_rd_0 = id_wen_0 && (id_rd_0 != '0) && (cnt[id_rd_0] == CNT_MAX);
      full_rd_1 = id_wen_1 && (id_rd_1 != '0) && (cnt[id_rd_1] == CNT_MAX);
      raw_pair  = id_wen_0 && (id_rd_0 != '0) &&
                  ((id_rs1_1 == id_rd_0) || (id_rs2_1 == id_rd_0));
      waw_pair  = id_wen_0 && id_wen_1 && (id_rd_0 != '0) && (id_rd_1 == id_rd_0);

      issue0_c  = srst_n && id_valid0 && ex_ready && !flush &&
                  !haz_rs1_0 && !haz_rs2_0 && !full_rd_0;
      issue1_c  = issue0_c && id_valid1 && !haz_rs1_1 && !haz_rs2_1 &&
                  !full_rd_1 && !raw_pair && !waw_pair;
   end

   assign issue0 = issue0_c;
   assign issue1 = issue1_c;

   logic [1:0]       inc_v;
   logic [1:0]       dec_v;
   logic [CNT_W+1:0] sum_v;

   always_comb begin
      inc_v      = '0;
      dec_v      = '0;
      sum_v      = '0;
      underflow  = '0;
      cnt_nxt[0] = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         inc_v = {1'b0, issue0_c && id_wen_0 && (id_rd_0 == r[4:0])} +
                 {1'b0, issue1_c && id_wen_1 && (id_rd_1 == r[4:0])};
         dec_v = {1'b0, wb_wen0 && (wb_waddr0 == r[4:0])} +
                 {1'b0, wb_wen1 && (wb_waddr1 == r[4:0])};
         sum_v = {2'b00, cnt[r[4:0]]} + {{CNT_W{1'b0}}, inc_v};
         if (flush) begin
            cnt_nxt[r[4:0]] = '0;
         end else if ({{CNT_W{1'b0}}, dec_v} > sum_v) begin
            cnt_nxt[r[4:0]] = '0;
            underflow[r]    = 1'b1;
         end else begin
            cnt_nxt[r[4:0]] = CNT_W'(sum_v - {{CNT_W{1'b0}}, dec_v});
         end
      end
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         for (int unsigned r = 0; r < 32; r++) cnt[r[4:0]] <= '0;
         busy_vec <= '0;
      end else begin
         for (int unsigned r = 0; r < 32; r++) begin
            cnt[r[4:0]]      <= cnt_nxt[r[4:0]];
            busy_vec[r[4:0]] <= (cnt_nxt[r[4:0]] != '0);
         end
      end
   end

   generate
      if (PERF != 0) begin : g_perf
         always_ff @(posedge clk or negedge srst_n) begin
            if (!srst_n)
               stall_cycles <= '0;
            else if (id_valid0 && ex_ready && !issue0_c)
               stall_cycles <= stall_cycles + 32'd1;
         end
      end else begin : g_no_perf
         assign stall_cycles = '0;
      end
   endgenerate

   a_no_underflow : assert property (@(posedge clk) disable iff (!srst_n) underflow == '0)
      else $error("riscv_scoreboard: writeback retired more than pending, regs=%h", underflow);

endmodule
